sram_window_sched: RTL
======================

# sram_window_sched

Round-robin scheduler that shares the single SRAM window scanner among `N_REQ` requesters (processing channels). It accepts one 44-bit window descriptor per request, validates it, drives the scanner's one-cycle START with the granted window, and tracks the scanner's `set` (busy) flag to detect completion. It also reports completion, errors and scan duration back to the owning requester. It sits between the channel controllers and the window scanner and is the scanner's only driver.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `CW`, 11: coordinate width. A descriptor is 4*CW = 44 bits.
- `ARM_TO`, 4: cycles to wait for scanner busy to rise after START before declaring a fault.
- `clk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req` in N_REQ: per-requester request level.
- `win_in` in N_REQ*4*CW: descriptor of requester i at `[i*44 +: 44]`. Layout: `[43:33]` x0, `[32:22]` y0, `[21:11]` x1, `[10:0]` y1.
- `ack` out N_REQ: one-cycle pulse when the descriptor is taken.
- `done` out N_REQ: one-cycle pulse when that requester's scan completes.
- `err` out N_REQ: one-cycle pulse on an invalid descriptor or a scanner fault.
- `scan_start` out 1: to scanner START, one-cycle pulse.
- `scan_window` out 44: to scanner window. Held stable from LAUNCH until return to IDLE.
- `scan_busy` in 1: scanner `set` flag.
- `owner` out clog2(N_REQ): index of the current grant.
- `busy` out 1: high in any state except IDLE.
- `scan_cycles` out 24: busy-cycle count of the last completed scan. Saturates at 2^24-1. Valid from the `done` pulse until the next `done`.

## Operation
- States: IDLE, LAUNCH, ARM, RUN, DONE.
- **IDLE:** arbitrates only if `|req` and `scan_busy==0`. The winner is the first asserted index after `last` in round-robin order, wrapping. In the same edge the scheduler latches `win_in[winner]` into `scan_window`, sets `owner`, pulses `ack[owner]` in the next cycle, and sets `last=owner`.
- **Validity:** a descriptor is valid iff x1 > x0 and y1 >= y0 (unsigned).
  - Valid: go to LAUNCH.
  - Invalid: pulse `err[owner]` together with `ack`, no START, and stay in IDLE.
- **LAUNCH:** `scan_start=1` for exactly one cycle, then go to ARM.
- **ARM:** if `scan_busy==1`, go to RUN. If `scan_busy` stays low for `ARM_TO` cycles, pulse `err[owner]`, set `scan_cycles=0`, and go to IDLE.
- **RUN:** increments the cycle counter (saturating) every cycle `scan_busy==1`. On `scan_busy==0`, go to DONE.
- **DONE:** `done[owner]=1` and `scan_cycles` is updated for one cycle, then go to IDLE.
- **Requester rules:**
  - Hold `req` and `win_in` stable until `ack`.
  - `req` still high in the first IDLE cycle after completion counts as a new request.
  - A `req` drop before `ack` withdraws the request.
- **Ordering:** `ack`, `done` and `err` are one-hot per cycle. `done` and `err` never pulse together for the same request.
- **Reset** (`rst_n==0` at an edge):
  - State goes to IDLE; `ack`, `done`, `err`, `scan_start` and `busy` go to 0.
  - `scan_window`, `owner` and `scan_cycles` go to 0.
  - `last` goes to N_REQ-1, so requester 0 has first priority.
- **Reset mid-scan:** the scanner is not reset. Because IDLE gates arbitration on `scan_busy==0`, no START is issued until the orphaned scan ends. That scan produces no `done`.

## Timing
- Request sampled in IDLE at edge T:
  - `ack` and `owner` valid in cycle T+1 (state LAUNCH, `scan_start=1`).
  - Scanner `set` rises at T+2 (ARM sees it).
  - RUN from T+3.
- `scan_busy` falls at edge E: DONE in cycle E+1, with `done` pulsing in that cycle. IDLE at E+2, so the next arbitration can grant at E+2 (the grant's `ack` is in cycle E+3).
- Back-to-back overhead between scans is 4 cycles (ack/launch, arm, done, idle).
- Invalid descriptor: `ack` and `err` in T+1, with `busy=0` throughout.

## Structure
- Shared package holds:
  - `CW`, `WIN_W=4*CW`, and the field offsets `X0_LSB=33`, `Y0_LSB=22`, `X1_LSB=11`, `Y1_LSB=0`.
  - State encoding localparams.
  - A `win_valid` function.
- One sub-module, `rr_arbiter`: combinational round-robin pick from `req` and `last`, producing a one-hot grant and its index. The FSM, latches and counter live in the top.

## Test plan
- **Single valid request:** `req[2]=1`, window (10,5,20,7), scanner model busy for 33 cycles.
  - `ack[2]` at T+1 and `scan_start` at T+1 with `scan_window` = the descriptor.
  - `done[2]` one cycle after busy falls, `scan_cycles=33`.
- **All four requesting continuously after reset:** grant order 0,1,2,3,0, with exactly one START per scan and no START while `scan_busy=1`.
- **Invalid descriptors:** (20,5,20,7) and (10,8,20,7) each produce `ack` and `err` in the same cycle, no `scan_start`, `busy=0`.
- **Scanner never raises busy:** `err[owner]` after `ARM_TO`=4 cycles, `scan_cycles=0`, and the next request is served normally.
- **Reset mid-RUN with `scan_busy` still high for 10 cycles:**
  - All outputs 0 after the reset edge.
  - A pending `req[1]` is not acked until `scan_busy` falls, and no `done` is issued for the orphaned scan.
- **Request withdrawal:** `req[3]` drops before grant while `req[1]` is held, so only requester 1 is acked.

Source files
------------

// File: rtl/sram_window_sched_pkg.sv
// Shared definitions for the SRAM window scheduler.
// Holds the descriptor geometry (coordinate width, field offsets), the scan
// cycle counter width, the FSM state encoding and the descriptor check.
package sram_window_sched_pkg;

    localparam int CW     = 11;
    localparam int WIN_W  = 4 * CW;
    localparam int X0_LSB = 33;
    localparam int Y0_LSB = 22;
    localparam int X1_LSB = 11;
    localparam int Y1_LSB = 0;

    localparam int              CNT_W   = 24;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_ARM    = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LAUNCH = ST_LAUNCH,
        S_ARM    = ST_ARM,
        S_RUN    = ST_RUN,
        S_DONE   = ST_DONE
    } state_t;

    // A window must be at least one column wide (x1 > x0); a single row is allowed.
    function automatic logic win_valid(input logic [WIN_W-1:0] w);
        logic [CW-1:0] x0;
        logic [CW-1:0] y0;
        logic [CW-1:0] x1;
        logic [CW-1:0] y1;
        x0 = w[X0_LSB +: CW];
        y0 = w[Y0_LSB +: CW];
        x1 = w[X1_LSB +: CW];
        y1 = w[Y1_LSB +: CW];
        return (x1 > x0) && (y1 >= y0);
    endfunction

endpackage

// File: rtl/sram_window_sched_if.sv
// Requester-side bundle of the SRAM window scheduler.
//   req    : per-requester request level (requester -> scheduler)
//   win_in : packed descriptors, requester i at [i*WIN_W +: WIN_W]
//   ack    : one-cycle pulse when the descriptor is taken
//   done   : one-cycle pulse when the requester's scan completes
//   err    : one-cycle pulse on an invalid descriptor or scanner fault
// Modport master is the requester side, slave is the scheduler side.
interface sram_window_sched_if #(
    parameter int N_REQ = 4
) ();

    logic [N_REQ-1:0]                                  req;
    logic [N_REQ*sram_window_sched_pkg::WIN_W-1:0]     win_in;
    logic [N_REQ-1:0]                                  ack;
    logic [N_REQ-1:0]                                  done;
    logic [N_REQ-1:0]                                  err;

    modport master (
        output req,
        output win_in,
        input  ack,
        input  done,
        input  err
    );

    modport slave (
        input  req,
        input  win_in,
        output ack,
        output done,
        output err
    );

endinterface

// File: rtl/sram_window_sched_rr_arbiter.sv
// Combinational round-robin pick.
//   req     : request levels
//   last    : index granted most recently; the search starts just after it
//   gnt     : one-hot grant (all zero when nothing requests)
//   gnt_idx : index of the grant
//   any     : at least one request present
module rr_arbiter
    import sram_window_sched_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] last,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            any
);

    // One extra bit so last + N never overflows before the wrap.
    localparam int SW = IDXW + 1;

    // Walk the candidates last+1, last+2, ... (mod N); first requester wins.
    always_comb begin
        logic [SW-1:0]   raw;
        logic [IDXW-1:0] pos;
        logic            hit;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        raw     = '0;
        pos     = '0;
        hit     = 1'b0;
        for (int i = 1; i <= N; i++) begin
            raw     = {1'b0, last} + SW'(i);
            raw     = (raw >= SW'(N)) ? raw - SW'(N) : raw;
            pos     = raw[IDXW-1:0];
            hit     = req[pos] & ~any;
            gnt     = hit ? (N'(1) << pos) : gnt;
            gnt_idx = hit ? pos : gnt_idx;
            any     = any | hit;
        end
    end

endmodule

// File: rtl/sram_window_sched.sv
// Round-robin scheduler sharing one SRAM window scanner among N_REQ requesters.
//   clk, rst_n  : clock, synchronous active-low reset
//   rq          : requester bundle (req/win_in in, ack/done/err pulses out)
//   scan_start  : one-cycle START to the scanner
//   scan_window : granted descriptor, stable from LAUNCH until back in IDLE
//   scan_busy   : scanner busy (set) flag
//   owner       : index of the current grant
//   busy        : high whenever the FSM is not in IDLE
//   scan_cycles : busy-cycle count of the last completed scan (saturating)
module sram_window_sched
    import sram_window_sched_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ARM_TO = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sram_window_sched_if.slave       rq,
    output logic                     scan_start,
    output logic [WIN_W-1:0]         scan_window,
    input  logic                     scan_busy,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic [CNT_W-1:0]         scan_cycles
);

    localparam int IDXW = $clog2(N_REQ);
    localparam int ACW  = $clog2(ARM_TO + 1);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [N_REQ-1:0]   err_q, err_d;
    logic               scan_start_q, scan_start_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [IDXW-1:0]    owner_q, owner_d;
    logic [IDXW-1:0]    last_q, last_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic [ACW-1:0]     arm_q, arm_d;

    logic [N_REQ-1:0]   gnt;
    logic [IDXW-1:0]    gnt_idx;
    logic               gnt_any;
    logic [WIN_W-1:0]   win_sel;
    logic [N_REQ-1:0]   owner_oh;

    rr_arbiter #(
        .N    (N_REQ),
        .IDXW (IDXW)
    ) u_arb (
        .req     (rq.req),
        .last    (last_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    // Descriptor of the arbitration winner.
    always_comb begin
        win_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_sel = (gnt_idx == IDXW'(i)) ? rq.win_in[i*WIN_W +: WIN_W] : win_sel;
        end
    end

    assign owner_oh = N_REQ'(1) << owner_q;

    // Next-state and next-output logic of the scheduling FSM.
    always_comb begin
        state_d      = state_q;
        ack_d        = '0;
        done_d       = '0;
        err_d        = '0;
        scan_start_d = 1'b0;
        win_d        = win_q;
        owner_d      = owner_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        arm_d        = arm_q;
        cycles_d     = cycles_q;
        case (state_q)
            S_IDLE: begin
                // Never start while an orphaned scan (e.g. after reset) is still running.
                if (gnt_any && !scan_busy) begin
                    ack_d   = gnt;
                    win_d   = win_sel;
                    owner_d = gnt_idx;
                    last_d  = gnt_idx;
                    if (win_valid(win_sel)) begin
                        state_d      = S_LAUNCH;
                        scan_start_d = 1'b1;
                    end else begin
                        err_d = gnt;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                state_d = S_ARM;
                arm_d   = '0;
                cnt_d   = '0;
            end
            S_ARM: begin
                // The cycle that sees busy rise is the first busy cycle counted.
                if (scan_busy) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_W'(1);
                end else if (arm_q == ACW'(ARM_TO - 1)) begin
                    state_d  = S_IDLE;
                    err_d    = owner_oh;
                    cycles_d = '0;
                end else begin
                    arm_d = arm_q + ACW'(1);
                end
            end
            S_RUN: begin
                if (scan_busy) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                end else begin
                    state_d  = S_DONE;
                    done_d   = owner_oh;
                    cycles_d = cnt_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ack_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
            scan_start_q <= 1'b0;
            win_q        <= '0;
            owner_q      <= '0;
            last_q       <= IDXW'(N_REQ - 1);
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            cycles_q     <= '0;
            arm_q        <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            err_q        <= err_d;
            scan_start_q <= scan_start_d;
            win_q        <= win_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            cycles_q     <= cycles_d;
            arm_q        <= arm_d;
        end
    end

    assign rq.ack      = ack_q;
    assign rq.done     = done_q;
    assign rq.err      = err_q;
    assign scan_start  = scan_start_q;
    assign scan_window = win_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign scan_cycles = cycles_q;

endmodule
